rr_arbiter: RTL and testbench

RR_ARBITER -- requirements
Module: rr_arbiter

---
 rtl/arbiter_pkg.sv | 13 +
 rtl/rr_pick.sv | 31 +++
 rtl/rr_arbiter.sv | 108 ++++++++++
 tb/tb_rr_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and default sizing for the round-robin arbiter.
package arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int unsigned DEF_NUM_REQ  = 4;
  localparam int unsigned DEF_MAX_HOLD = 8;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority search: first set req bit at or above ptr, wrapping.
module rr_pick
  import arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       valid
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  int unsigned idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!valid && req[IW'(idx)]) begin
        valid  = 1'b1;
        winner = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with per-grant hold limit, release on done/req-drop/timeout,
// and a one-cycle gap between grants.
module rr_arbiter
  import arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         done,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       busy,
  output logic                       timeout
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(MAX_HOLD + 1);

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   pick_id_c;
  logic            pick_valid_c;
  logic [CW-1:0]   cnt_inc_c;
  logic            done_hit_c;
  logic            req_drop_c;
  logic            cnt_hit_c;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_id_c),
    .valid  (pick_valid_c)
  );

  // Release causes for the current grantee; the counter only counts while granted.
  always_comb begin
    cnt_inc_c  = cnt + CW'(1);
    done_hit_c = done[gnt_id];
    req_drop_c = !req[gnt_id];
    cnt_hit_c  = (cnt_inc_c == CW'(MAX_HOLD));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      gnt     <= '0;
      gnt_id  <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid_c) begin
            state  <= GRANT;
            gnt    <= NUM_REQ'(1) << pick_id_c;
            gnt_id <= pick_id_c;
            busy   <= 1'b1;
            cnt    <= '0;
            ptr    <= (pick_id_c == IW'(NUM_REQ - 1)) ? '0 : pick_id_c + IW'(1);
          end
        end
        GRANT: begin
          cnt <= (cnt == CW'(MAX_HOLD)) ? cnt : cnt_inc_c;
          if (done_hit_c || req_drop_c || cnt_hit_c) begin
            state   <= GAP;
            gnt     <= '0;
            busy    <= 1'b0;
            // An explicit release in the same cycle as expiry is not a timeout.
            timeout <= cnt_hit_c && !done_hit_c && !req_drop_c;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  default clocking cb @(posedge clk); endclocking

  a_latency: assert property (disable iff (rst)
    (state == IDLE && req != '0) |=> (busy && gnt != '0));

  a_release: assert property (disable iff (rst)
    (state == GRANT && (done_hit_c || req_drop_c)) |=> (!busy && gnt == '0 && !timeout));

  a_expire: assert property (disable iff (rst)
    (state == GRANT && cnt_hit_c && !done_hit_c && !req_drop_c) |=> (timeout && !busy && gnt == '0));

  a_timeout_gap: assert property (disable iff (rst)
    timeout |-> (state == GAP));

  a_onehot: assert property (disable iff (rst)
    $onehot0(gnt));

  a_busy_grant: assert property (disable iff (rst)
    (state == GRANT) |-> (busy && $onehot(gnt)));

  a_idle_quiet: assert property (disable iff (rst)
    (state != GRANT) |-> (!busy && gnt == '0));

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed cycle-exact bench for rr_arbiter with hand-computed expectations.
module tb_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  rr_arbiter #(.NUM_REQ(4), .MAX_HOLD(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    done = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    done = '0;
    tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_id", 32'(gnt_id), 32'h0);
    chk("rst_to", 32'(timeout), 32'h0);
    rst = 1'b0;

    // Timeout of requester 0 after 8 cycles, then round-robin moves to 2.
    req = 4'b0101;
    tick();
    chk("t1_gnt0", 32'(gnt), 32'h1);
    chk("t1_id0", 32'(gnt_id), 32'h0);
    chk("t1_busy", 32'(busy), 32'h1);
    for (int c = 2; c <= 8; c++) begin
      tick();
      chk("t1_hold_gnt", 32'(gnt), 32'h1);
      chk("t1_hold_to", 32'(timeout), 32'h0);
    end
    tick();
    chk("t1_rel_gnt", 32'(gnt), 32'h0);
    chk("t1_rel_to", 32'(timeout), 32'h1);
    chk("t1_rel_busy", 32'(busy), 32'h0);
    tick();
    chk("t1_gap_to", 32'(timeout), 32'h0);
    chk("t1_gap_gnt", 32'(gnt), 32'h0);
    tick();
    chk("t1_gnt2", 32'(gnt), 32'h4);
    chk("t1_id2", 32'(gnt_id), 32'h2);

    // done[2] in the 3rd grant cycle releases without timeout.
    do_reset();
    req = 4'b0100;
    tick();
    chk("t2_gnt", 32'(gnt), 32'h4);
    tick();
    tick();
    done = 4'b0100;
    tick();
    done = 4'b0000;
    chk("t2_rel_gnt", 32'(gnt), 32'h0);
    chk("t2_rel_to", 32'(timeout), 32'h0);
    chk("t2_rel_busy", 32'(busy), 32'h0);
    tick();
    chk("t2_idle_busy", 32'(busy), 32'h0);
    tick();
    chk("t2_regrant", 32'(gnt), 32'h4);

    // Continuous requests from all four: order 0,1,2,3,0.
    do_reset();
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      logic [1:0] exp_id;
      exp_id = 2'(k % 4);
      chk("t3_id", 32'(gnt_id), 32'(exp_id));
      chk("t3_gnt", 32'(gnt), 32'(4'b0001 << exp_id));
      tick();
      done = 4'b0001 << exp_id;
      tick();
      done = 4'b0000;
      chk("t3_rel_busy", 32'(busy), 32'h0);
      chk("t3_rel_to", 32'(timeout), 32'h0);
      tick();
      tick();
    end

    // done coincides with the counter reaching 8: done wins.
    do_reset();
    req = 4'b0010;
    tick();
    chk("t4_gnt", 32'(gnt), 32'h2);
    for (int c = 2; c <= 8; c++) tick();
    chk("t4_c8_gnt", 32'(gnt), 32'h2);
    done = 4'b0010;
    tick();
    done = 4'b0000;
    chk("t4_rel_gnt", 32'(gnt), 32'h0);
    chk("t4_rel_to", 32'(timeout), 32'h0);

    // Reset in the 4th grant cycle of requester 3.
    do_reset();
    req = 4'b1000;
    tick();
    chk("t5_gnt", 32'(gnt), 32'h8);
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("t5_async_gnt", 32'(gnt), 32'h0);
    chk("t5_async_busy", 32'(busy), 32'h0);
    chk("t5_async_to", 32'(timeout), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("t5_regrant", 32'(gnt), 32'h8);
    chk("t5_regrant_id", 32'(gnt_id), 32'h3);
    chk("t5_regrant_to", 32'(timeout), 32'h0);

    // Grantee held despite other req changes; dropping req[1] releases.
    do_reset();
    req = 4'b0010;
    tick();
    chk("t6_gnt", 32'(gnt), 32'h2);
    req = 4'b0011;
    tick();
    chk("t6_keep", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick();
    chk("t6_rel_gnt", 32'(gnt), 32'h0);
    chk("t6_rel_to", 32'(timeout), 32'h0);
    tick();
    chk("t6_gap_to", 32'(timeout), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
